// File: rtl/nmr_echo_packer_pkg.sv
// Shared definitions for the NMR echo packer: state encoding and default widths.
package nmr_pkg;
    localparam int ADC_DATA_WIDTH_DEF         = 16;
    localparam int SAMPLES_PER_ECHO_WIDTH_DEF = 32;
    localparam int ECHO_PER_SCAN_WIDTH_DEF    = 32;
    localparam int FIFO_ADDR_WIDTH_DEF        = 4;
    localparam int DROP_CNT_WIDTH_DEF         = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;
endpackage

// File: rtl/nmr_echo_packer_if.sv
// ADC sample input and packed-word output handshake of the echo packer.
interface nmr_echo_packer_if import nmr_pkg::*; #(
    parameter int DW = ADC_DATA_WIDTH_DEF
) ();
    logic [DW-1:0]   ADC_OUT_DATA;
    logic            ADC_DATA_VALID;
    logic [2*DW-1:0] DOUT;
    logic            DOUT_VALID;
    logic            DOUT_READY;
    logic            DOUT_LAST;

    modport master (
        input  ADC_OUT_DATA, ADC_DATA_VALID, DOUT_READY,
        output DOUT, DOUT_VALID, DOUT_LAST
    );

    modport slave (
        output ADC_OUT_DATA, ADC_DATA_VALID, DOUT_READY,
        input  DOUT, DOUT_VALID, DOUT_LAST
    );
endinterface

// File: rtl/nmr_echo_packer_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible while not empty.
module nmr_sync_fifo import nmr_pkg::*; #(
    parameter int DATA_WIDTH = 33,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                       (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_do_rd   = i_rd_en && !o_empty;
    // A read in the same cycle frees the slot, so a full FIFO can still take a write.
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/nmr_echo_packer.sv
// Packs ADC sample pairs into 32-bit words for one scan, tags the final word LAST.
// States: IDLE wait for START | CAPTURE pack samples | FLUSH write LAST word | DRAIN wait LAST handoff
module nmr_echo_packer import nmr_pkg::*; #(
    parameter int ADC_DATA_WIDTH         = ADC_DATA_WIDTH_DEF,
    parameter int SAMPLES_PER_ECHO_WIDTH = SAMPLES_PER_ECHO_WIDTH_DEF,
    parameter int ECHO_PER_SCAN_WIDTH    = ECHO_PER_SCAN_WIDTH_DEF,
    parameter int FIFO_ADDR_WIDTH        = FIFO_ADDR_WIDTH_DEF,
    parameter int DROP_CNT_WIDTH         = DROP_CNT_WIDTH_DEF
) (
    input  logic                              ADC_CLK,
    input  logic                              RESET_N,
    input  logic                              START,
    input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
    nmr_echo_packer_if.master                 bus,
    output logic                              BUSY,
    output logic                              OVERFLOW,
    output logic [DROP_CNT_WIDTH-1:0]         DROP_CNT
);
    localparam int WW = 2 * ADC_DATA_WIDTH;

    state_t                            r_state;
    logic                              r_busy;
    logic [SAMPLES_PER_ECHO_WIDTH-1:0] r_spe;
    logic [ECHO_PER_SCAN_WIDTH-1:0]    r_eps;
    logic [SAMPLES_PER_ECHO_WIDTH-1:0] r_sidx;
    logic [ECHO_PER_SCAN_WIDTH-1:0]    r_eidx;
    logic                              r_half;
    logic [ADC_DATA_WIDTH-1:0]         r_low;
    logic [WW-1:0]                     r_pend;
    logic                              r_ovf;
    logic [DROP_CNT_WIDTH-1:0]         r_drop;

    logic          w_full;
    logic          w_empty;
    logic [WW:0]   w_fifo_q;
    logic          w_rd;
    logic          w_space;
    logic          w_sample;
    logic          w_end_echo;
    logic          w_final;
    logic          w_pair_wr;
    logic          w_flush_wr;
    logic          w_wr_en;
    logic [WW:0]   w_wr_data;

    assign w_rd       = !w_empty && bus.DOUT_READY;
    assign w_space    = !w_full || w_rd;
    assign w_sample   = (r_state == ST_CAPTURE) && bus.ADC_DATA_VALID;
    assign w_end_echo = (r_sidx == r_spe - SAMPLES_PER_ECHO_WIDTH'(1));
    assign w_final    = w_end_echo && (r_eidx == r_eps - ECHO_PER_SCAN_WIDTH'(1));
    assign w_pair_wr  = w_sample && r_half && !w_final;
    assign w_flush_wr = (r_state == ST_FLUSH) && w_space;
    assign w_wr_en    = (w_pair_wr && w_space) || w_flush_wr;
    assign w_wr_data  = (r_state == ST_FLUSH) ? {1'b1, r_pend}
                                              : {1'b0, bus.ADC_OUT_DATA, r_low};

    nmr_sync_fifo #(
        .DATA_WIDTH (WW + 1),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .i_clk     (ADC_CLK),
        .i_rst_n   (RESET_N),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (bus.DOUT_READY),
        .o_rd_data (w_fifo_q),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.DOUT       = w_empty ? '0 : w_fifo_q[WW-1:0];
    assign bus.DOUT_VALID = !w_empty;
    assign bus.DOUT_LAST  = !w_empty && w_fifo_q[WW];
    assign BUSY           = r_busy;
    assign OVERFLOW       = r_ovf;
    assign DROP_CNT       = r_drop;

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_spe   <= '0;
            r_eps   <= '0;
            r_sidx  <= '0;
            r_eidx  <= '0;
            r_half  <= 1'b0;
            r_low   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START && (SAMPLES_PER_ECHO != '0) && (ECHO_PER_SCAN != '0)) begin
                        r_spe   <= SAMPLES_PER_ECHO;
                        r_eps   <= ECHO_PER_SCAN;
                        r_sidx  <= '0;
                        r_eidx  <= '0;
                        r_half  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_drop  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_sample) begin
                        if (w_final) begin
                            // An odd sample total leaves the upper half of the LAST word zero.
                            r_pend  <= r_half ? {bus.ADC_OUT_DATA, r_low}
                                              : {{ADC_DATA_WIDTH{1'b0}}, bus.ADC_OUT_DATA};
                            r_half  <= 1'b0;
                            r_state <= ST_FLUSH;
                        end else begin
                            if (!r_half) begin
                                r_low  <= bus.ADC_OUT_DATA;
                                r_half <= 1'b1;
                            end else begin
                                r_half <= 1'b0;
                                if (!w_space) begin
                                    r_ovf <= 1'b1;
                                    if (r_drop != '1) r_drop <= r_drop + DROP_CNT_WIDTH'(1);
                                end
                            end
                            if (w_end_echo) begin
                                r_sidx <= '0;
                                r_eidx <= r_eidx + ECHO_PER_SCAN_WIDTH'(1);
                            end else begin
                                r_sidx <= r_sidx + SAMPLES_PER_ECHO_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_space) begin
                        r_pend  <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_rd && bus.DOUT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
